// File: rtl/genius_pkg.sv
// genius_pkg: definitions shared by the Genius (Simon) game blocks.
//   state_e   - sequencer states
//   ColorW    - width of a colour code from the pattern ROM
//   LedW      - width of the one-hot LED / button vectors
//   onehot()  - colour code to one-hot LED pattern (also used by the LED driver)
package genius_pkg;

    localparam int unsigned ColorW = 2;
    localparam int unsigned LedW   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StShowOn,
        StShowOff,
        StWaitIn,
        StWin,
        StLose
    } state_e;

    function automatic logic [LedW-1:0] onehot(input logic [ColorW-1:0] color);
        logic [LedW-1:0] v;
        v = '0;
        v[color] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/genius_tick_timer.sv
// genius_tick_timer: tick-qualified down-counter used for the press timeout.
//   clk, R_n - clock and asynchronous active-low reset
//   en       - counting allowed (sequencer is waiting for input)
//   load     - reload the counter with TICKS
//   tick     - prescaler pulse; decrements while en
//   expire   - the tick that would take the count from 1 to 0
module genius_tick_timer #(
    parameter int unsigned TICKS = 8
) (
    input  logic clk,
    input  logic R_n,
    input  logic en,
    input  logic load,
    input  logic tick,
    output logic expire
);

    localparam int unsigned W = (TICKS < 2) ? 1 : $clog2(TICKS + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= W'(TICKS);
        end else if (en && tick && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Not gated by load: the caller only honours expire when no press is present,
    // and a press is the only reload source while waiting.
    assign expire = en && tick && (cnt_q == W'(1));

endmodule

// File: rtl/genius_round_ctrl.sv
// genius_round_ctrl: Genius game sequencer. Replays the pattern up to the current
// round, checks the player's presses and advances, wins or loses.
//   clk, R_n   - clock and asynchronous active-low reset
//   start      - begin a new game (honoured only in IDLE/WIN/LOSE)
//   level      - index of the final round, latched at start
//   tick       - prescaler pulse pacing the display
//   btn        - synchronised press pulses, one bit per colour
//   seq_color  - pattern ROM data at seq_addr (asynchronous ROM)
//   seq_addr   - pattern ROM address (index counter)
//   led        - one-hot colour display, 1111 on win
//   round      - current round, 0-based
//   user_turn  - waiting for a press
//   busy       - game in progress
//   win, lose  - terminal flags, held until the next start
// Build option: define GENIUS_TIMEOUT_EN to lose after TIMEOUT_TICKS ticks without a press.
module genius_round_ctrl
    import genius_pkg::*;
#(
    parameter int unsigned SIZE          = 4,
    parameter int unsigned TIMEOUT_TICKS = 8
) (
    input  logic              clk,
    input  logic              R_n,
    input  logic              start,
    input  logic [SIZE-1:0]   level,
    input  logic              tick,
    input  logic [LedW-1:0]   btn,
    input  logic [ColorW-1:0] seq_color,
    output logic [SIZE-1:0]   seq_addr,
    output logic [LedW-1:0]   led,
    output logic [SIZE-1:0]   round,
    output logic              user_turn,
    output logic              busy,
    output logic              win,
    output logic              lose
);

    state_e          state_q, state_d;
    logic [SIZE-1:0] round_q, round_d;
    logic [SIZE-1:0] idx_q, idx_d;
    logic [SIZE-1:0] level_q, level_d;
    logic            timeout_hit;
    logic            pressed;

    assign pressed = (btn != '0);

`ifdef GENIUS_TIMEOUT_EN
    logic timer_load;

    // Reload on entry to WAIT_IN and on every accepted press that stays there.
    assign timer_load = (state_d == StWaitIn) && ((state_q != StWaitIn) || pressed);

    genius_tick_timer #(
        .TICKS (TIMEOUT_TICKS)
    ) u_timer (
        .clk    (clk),
        .R_n    (R_n),
        .en     (state_q == StWaitIn),
        .load   (timer_load),
        .tick   (tick),
        .expire (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_TICKS;
    assign timeout_hit        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state_q <= StIdle;
            round_q <= '0;
            idx_q   <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            idx_q   <= idx_d;
            level_q <= level_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        idx_d   = idx_q;
        level_d = level_q;
        unique case (state_q)
            StIdle, StWin, StLose: begin
                if (start) begin
                    level_d = level;
                    round_d = '0;
                    idx_d   = '0;
                    state_d = StShowOn;
                end
            end
            StShowOn: begin
                if (tick) state_d = StShowOff;
            end
            StShowOff: begin
                if (tick) begin
                    if (idx_q == round_q) begin
                        idx_d   = '0;
                        state_d = StWaitIn;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StShowOn;
                    end
                end
            end
            StWaitIn: begin
                if (pressed) begin
                    // onehot() is always one-hot, so multi-bit presses fail here too.
                    if (btn != onehot(seq_color)) begin
                        state_d = StLose;
                    end else if (idx_q != round_q) begin
                        idx_d = idx_q + 1'b1;
                    end else if (round_q == level_q) begin
                        state_d = StWin;
                    end else begin
                        round_d = round_q + 1'b1;
                        idx_d   = '0;
                        state_d = StShowOn;
                    end
                end else if (timeout_hit) begin
                    state_d = StLose;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: decoded from registered state; led follows the ROM at the registered address.
    always_comb begin
        led       = '0;
        user_turn = 1'b0;
        busy      = 1'b0;
        win       = 1'b0;
        lose      = 1'b0;
        unique case (state_q)
            StShowOn: begin
                led  = onehot(seq_color);
                busy = 1'b1;
            end
            StShowOff: busy = 1'b1;
            StWaitIn: begin
                user_turn = 1'b1;
                busy      = 1'b1;
            end
            StWin: begin
                win = 1'b1;
                led = '1;
            end
            StLose:  lose = 1'b1;
            default: ;
        endcase
    end

    assign seq_addr = idx_q;
    assign round    = round_q;

endmodule

// File: tb/tb_genius_round_ctrl.sv
module tb_genius_round_ctrl;

    logic       clk = 1'b0;
    logic       R_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] level = '0;
    logic       tick = 1'b0;
    logic [3:0] btn = '0;
    logic [1:0] seq_color;
    logic [3:0] seq_addr;
    logic [3:0] led;
    logic [3:0] round;
    logic       user_turn, busy, win, lose;

    logic [1:0] pattern [16];
    int n_checks = 0;
    int n_fail = 0;

    assign seq_color = pattern[seq_addr];

    genius_round_ctrl #(
        .SIZE          (4),
        .TIMEOUT_TICKS (3)
    ) dut (
        .clk       (clk),
        .R_n       (R_n),
        .start     (start),
        .level     (level),
        .tick      (tick),
        .btn       (btn),
        .seq_color (seq_color),
        .seq_addr  (seq_addr),
        .led       (led),
        .round     (round),
        .user_turn (user_turn),
        .busy      (busy),
        .win       (win),
        .lose      (lose)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] oh(input logic [1:0] c);
        logic [3:0] v;
        v = 4'd1;
        return v << c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        step();
        btn = '0;
    endtask

    task automatic do_start(input logic [3:0] lvl);
        level = lvl;
        start = 1'b1;
        step();
        start = 1'b0;
        level = '0;
    endtask

    task automatic load_pattern(input logic [1:0] p0, input logic [1:0] p1,
                                input logic [1:0] p2, input logic [1:0] p3);
        for (int i = 0; i < 16; i++) pattern[i] = 2'd0;
        pattern[0] = p0;
        pattern[1] = p1;
        pattern[2] = p2;
        pattern[3] = p3;
    endtask

    task automatic test_reset();
        R_n = 1'b0;
        #3;
        n_checks++;
        if ({led, round, seq_addr, user_turn, busy, win, lose} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got led=%b round=%0d addr=%0d ut=%b busy=%b win=%b lose=%b, want all 0",
                     led, round, seq_addr, user_turn, busy, win, lose);
        end
        step();
        R_n = 1'b1;
        step();
        n_checks++;
        if ({busy, win, lose} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got busy/win/lose=%b, want 000", {busy, win, lose});
        end
    endtask

    task automatic test_level0();
        load_pattern(2'd2, 2'd0, 2'd0, 2'd0);
        do_start(4'd0);
        step();  // no tick: display holds
        n_checks++;
        if (led !== 4'b0100 || busy !== 1'b1 || user_turn !== 1'b0) begin
            n_fail++;
            $display("FAIL l0_show_on: got led=%b busy=%b ut=%b, want 0100 1 0", led, busy, user_turn);
        end
        pulse_tick();
        n_checks++;
        if (led !== 4'b0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL l0_show_off: got led=%b busy=%b, want 0000 1", led, busy);
        end
        pulse_tick();
        n_checks++;
        if (user_turn !== 1'b1 || led !== 4'b0000) begin
            n_fail++;
            $display("FAIL l0_wait_in: got ut=%b led=%b, want 1 0000", user_turn, led);
        end
        press(4'b0100);
        n_checks++;
        if (win !== 1'b1 || led !== 4'b1111 || busy !== 1'b0 || user_turn !== 1'b0) begin
            n_fail++;
            $display("FAIL l0_win: got win=%b led=%b busy=%b ut=%b, want 1 1111 0 0",
                     win, led, busy, user_turn);
        end
    endtask

    task automatic test_level2();
        load_pattern(2'd1, 2'd3, 2'd0, 2'd0);
        do_start(4'd2);
        for (int r = 0; r <= 2; r++) begin
            for (int i = 0; i <= r; i++) begin
                n_checks++;
                if (led !== oh(pattern[i]) || seq_addr !== 4'(i)) begin
                    n_fail++;
                    $display("FAIL l2_show r%0d i%0d: got led=%b addr=%0d, want %b %0d",
                             r, i, led, seq_addr, oh(pattern[i]), i);
                end
                pulse_tick();
                n_checks++;
                if (led !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL l2_dark r%0d i%0d: got led=%b, want 0000", r, i, led);
                end
                pulse_tick();
            end
            n_checks++;
            if (user_turn !== 1'b1 || round !== 4'(r) || seq_addr !== 4'd0) begin
                n_fail++;
                $display("FAIL l2_turn r%0d: got ut=%b round=%0d addr=%0d, want 1 %0d 0",
                         r, user_turn, round, seq_addr, r);
            end
            for (int i = 0; i <= r; i++) press(oh(pattern[i]));
            if (r < 2) begin
                n_checks++;
                if (round !== 4'(r + 1) || user_turn !== 1'b0 || win !== 1'b0) begin
                    n_fail++;
                    $display("FAIL l2_advance r%0d: got round=%0d ut=%b win=%b, want %0d 0 0",
                             r, round, user_turn, win, r + 1);
                end
            end
        end
        n_checks++;
        if (win !== 1'b1 || lose !== 1'b0 || round !== 4'd2) begin
            n_fail++;
            $display("FAIL l2_win: got win=%b lose=%b round=%0d, want 1 0 2", win, lose, round);
        end
    endtask

    task automatic test_wrong_press();
        load_pattern(2'd1, 2'd3, 2'd0, 2'd2);
        do_start(4'd3);
        pulse_tick();
        pulse_tick();
        press(4'b0010);
        n_checks++;
        if (round !== 4'd1 || led !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrong_r1: got round=%0d led=%b, want 1 0010", round, led);
        end
        repeat (4) pulse_tick();
        press(4'b0010);
        n_checks++;
        if (user_turn !== 1'b1 || seq_addr !== 4'd1) begin
            n_fail++;
            $display("FAIL wrong_idx: got ut=%b addr=%0d, want 1 1", user_turn, seq_addr);
        end
        press(4'b0001);
        n_checks++;
        if (lose !== 1'b1 || led !== 4'b0000 || busy !== 1'b0 || win !== 1'b0) begin
            n_fail++;
            $display("FAIL wrong_lose: got lose=%b led=%b busy=%b win=%b, want 1 0000 0 0",
                     lose, led, busy, win);
        end
    endtask

    task automatic test_ignore();
        load_pattern(2'd1, 2'd2, 2'd0, 2'd0);
        do_start(4'd1);
        n_checks++;
        if (lose !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_restart: got lose=%b busy=%b, want 0 1", lose, busy);
        end
        press(4'b0001);
        n_checks++;
        if (led !== 4'b0010 || seq_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL ign_btn_on: got led=%b addr=%0d, want 0010 0", led, seq_addr);
        end
        do_start(4'd5);
        n_checks++;
        if (led !== 4'b0010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_start_on: got led=%b busy=%b, want 0010 1", led, busy);
        end
        pulse_tick();
        press(4'b0010);
        n_checks++;
        if (led !== 4'b0000 || user_turn !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_btn_off: got led=%b ut=%b busy=%b, want 0000 0 1", led, user_turn, busy);
        end
        pulse_tick();
        do_start(4'd0);
        pulse_tick();
        n_checks++;
        if (user_turn !== 1'b1 || round !== 4'd0) begin
            n_fail++;
            $display("FAIL ign_wait: got ut=%b round=%0d, want 1 0", user_turn, round);
        end
        press(4'b0011);
        n_checks++;
        if (lose !== 1'b1 || user_turn !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_multi_lose: got lose=%b ut=%b, want 1 0", lose, user_turn);
        end
    endtask

`ifdef GENIUS_TIMEOUT_EN
    task automatic test_timeout();
        load_pattern(2'd1, 2'd2, 2'd0, 2'd0);
        do_start(4'd1);
        pulse_tick();
        pulse_tick();
        pulse_tick();
        pulse_tick();
        n_checks++;
        if (user_turn !== 1'b1 || lose !== 1'b0) begin
            n_fail++;
            $display("FAIL to_two_ticks: got ut=%b lose=%b, want 1 0", user_turn, lose);
        end
        pulse_tick();
        n_checks++;
        if (lose !== 1'b1) begin
            n_fail++;
            $display("FAIL to_expire: got lose=%b, want 1", lose);
        end
        do_start(4'd1);
        pulse_tick();
        pulse_tick();
        pulse_tick();
        pulse_tick();
        tick = 1'b1;
        btn  = 4'b0010;
        step();
        tick = 1'b0;
        btn  = '0;
        n_checks++;
        if (lose !== 1'b0 || round !== 4'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL to_press_wins: got lose=%b round=%0d busy=%b, want 0 1 1", lose, round, busy);
        end
    endtask
`endif

    task automatic test_reset_mid_game();
        R_n = 1'b0;
        step();
        R_n = 1'b1;
        load_pattern(2'd1, 2'd3, 2'd0, 2'd2);
        do_start(4'd3);
        pulse_tick();
        pulse_tick();
        press(4'b0010);
        repeat (4) pulse_tick();
        press(4'b0010);
        press(4'b1000);
        n_checks++;
        if (round !== 4'd2 || led !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_setup: got round=%0d led=%b, want 2 0010", round, led);
        end
        #2;
        R_n = 1'b0;
        #1;
        n_checks++;
        if ({led, round, seq_addr, user_turn, busy, win, lose} !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_async_reset: got led=%b round=%0d addr=%0d busy=%b, want all 0",
                     led, round, seq_addr, busy);
        end
        step();
        R_n = 1'b1;
        do_start(4'd0);
        n_checks++;
        if (round !== 4'd0 || seq_addr !== 4'd0 || led !== 4'b0010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_restart: got round=%0d addr=%0d led=%b busy=%b, want 0 0 0010 1",
                     round, seq_addr, led, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pattern[i] = 2'd0;
        test_reset();
        test_level0();
        test_level2();
        test_wrong_press();
        test_ignore();
`ifdef GENIUS_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_game();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
